// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings.
package serial_subtractor_pkg;

  localparam int unsigned StateW = 2;

  localparam logic [StateW-1:0] S_IDLE = 2'd0;
  localparam logic [StateW-1:0] S_RUN  = 2'd1;
  localparam logic [StateW-1:0] S_DONE = 2'd2;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor slice: d = a - b - bi, with borrow-out bo.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bi;
  assign bo = (~a & b) | (~(a ^ b) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock behind valid/ready,
// producing the difference plus borrow, signed-overflow and zero flags.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  logic [StateW-1:0] state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, res_q, res_d, d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              br_q, br_d;
  logic              borrow_q, borrow_d, ovf_q, ovf_d, zero_q, zero_d;
  logic              fs_d, fs_bo;
  logic [WIDTH-1:0]  res_shift;

  full_subtractor u_fs (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  assign res_shift = {fs_d, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          cnt_d   = '0;
          br_d    = 1'b0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = res_shift;
        br_d  = fs_bo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          // On the last bit the slice inputs are the operand sign bits.
          d_d      = res_shift;
          borrow_d = fs_bo;
          ovf_d    = (a_q[0] ^ b_q[0]) & (a_q[0] ^ fs_d);
          zero_d   = (res_shift == '0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign d         = d_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=4): directed vectors, backpressure,
// mid-run reset and a shuffled sweep of all operand pairs against an arithmetic model.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] d;
  logic         borrow, ovf, zero;

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views of the operands.
  function automatic vec_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    vec_t r;
    int   sa, sb, sd;
    sa = ma[W-1] ? int'(ma) - 16 : int'(ma);
    sb = mb[W-1] ? int'(mb) - 16 : int'(mb);
    sd = sa - sb;
    r.a      = ma;
    r.b      = mb;
    r.d      = W'((int'(ma) - int'(mb)) & 15);
    r.borrow = (int'(ma) < int'(mb));
    r.ovf    = (sd < -8) || (sd > 7);
    r.zero   = (r.d == 0);
    return r;
  endfunction

  // Accept one pair, wait for the result, hold it `hold` cycles, then hand it off.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold,
                        output vec_t res, output int lat, output logic hs_ok);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_valid = 1'b1;
    a = ta;
    b = tb_v;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res.a = ta;
    res.b = tb_v;
    res.d = d;
    res.borrow = borrow;
    res.ovf = ovf;
    res.zero = zero;
    repeat (hold) @(posedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    hs_ok = !out_valid && in_ready;
  endtask

  task automatic check_op(input string tag, input vec_t got, input vec_t exp, input int lat,
                          input logic hs_ok);
    check({tag, "_d"}, int'(got.d), int'(exp.d));
    check({tag, "_borrow"}, int'(got.borrow), int'(exp.borrow));
    check({tag, "_ovf"}, int'(got.ovf), int'(exp.ovf));
    check({tag, "_zero"}, int'(got.zero), int'(exp.zero));
    check({tag, "_latency"}, lat, W);
    check({tag, "_handshake"}, int'(hs_ok), 1);
  endtask

  initial begin
    vec_t vecs[6];
    vec_t got, exp_v;
    int   lat;
    logic hs_ok;
    logic [W-1:0] d_hold;
    logic f_hold;
    int   perm[256];

    vecs[0] = '{a: 4'h7, b: 4'h3, d: 4'h4, borrow: 1'b0, ovf: 1'b0, zero: 1'b0};
    vecs[1] = '{a: 4'h3, b: 4'h7, d: 4'hC, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};
    vecs[2] = '{a: 4'h8, b: 4'h1, d: 4'h7, borrow: 1'b0, ovf: 1'b1, zero: 1'b0};
    vecs[3] = '{a: 4'h7, b: 4'hF, d: 4'h8, borrow: 1'b1, ovf: 1'b1, zero: 1'b0};
    vecs[4] = '{a: 4'h5, b: 4'h5, d: 4'h0, borrow: 1'b0, ovf: 1'b0, zero: 1'b1};
    vecs[5] = '{a: 4'h0, b: 4'h1, d: 4'hF, borrow: 1'b1, ovf: 1'b0, zero: 1'b0};

    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_d", int'(d), 0);
    check("rst_flags", int'({borrow, ovf, zero}), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, i % 3, got, lat, hs_ok);
      check_op($sformatf("vec%0d", i), got, vecs[i], lat, hs_ok);
    end

    // Backpressure: result held for 10 cycles while in_valid pulses are ignored.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'h2;
    b = 4'h9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("bp_valid", int'(out_valid), 1);
    d_hold = d;
    f_hold = borrow;
    check("bp_d", int'(d), 9);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = i[0];
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk);
      #1;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_ready", int'(in_ready), 0);
      check("bp_hold_d", int'(d), int'(d_hold));
      check("bp_hold_flags", int'({borrow, ovf, zero}), int'({f_hold, 1'b1, 1'b0}));
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);

    // Reset two cycles into RUN aborts the op; the next op is clean.
    @(negedge clk);
    in_valid = 1'b1;
    a = 4'hB;
    b = 4'h3;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_in_ready", int'(in_ready), 1);
    check("abort_d", int'(d), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(4'h6, 4'h2, 0, got, lat, hs_ok);
    check_op("post_abort", got, model(4'h6, 4'h2), lat, hs_ok);

    // Every operand pair in shuffled order with random gaps and backpressure.
    for (int i = 0; i < 256; i++) perm[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = perm[i];
      perm[i] = perm[j];
      perm[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      exp_v = model(W'(perm[i] >> 4), W'(perm[i] & 15));
      run_op(exp_v.a, exp_v.b, int'($urandom_range(3, 0)), got, lat, hs_ok);
      check_op($sformatf("sweep_%0h_%0h", exp_v.a, exp_v.b), got, exp_v, lat, hs_ok);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
